core_seq: RTL and testbench
===========================

# core_seq

Instruction sequencer for the attention/MAC core. On a `start` pulse it emits the 19-bit `inst` word, one word per cycle, to run one complete pass:

- load the kernel rows from kmem into the MAC array;
- stream query rows from qmem;
- drain the output FIFO into psum memory;
- optionally run the two-pass normalization (accumulate, then divide) and write the normalized rows back to psum memory.

It sits directly above the core and is the only driver of its `inst` bus.

## Interface
Parameters:
- `col`, 8: MAC array columns; the kernel load issues `col` rows.
- `kflush`, 2: idle cycles between kernel load and execute.
- `norm_base`, 8: psum address of the first normalized row.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle request; sampled only in IDLE.
- `num_q`  in  3: query row count minus 1 (n = num_q+1, range 1..8); latched at start.
- `norm_en`  in  1: run the normalization phases; latched at start.
- `fifo_valid`  in  1: core output-FIFO valid flag (head entry present).
- `inst`  out  19: core instruction word; registered.
- `busy`  out  1: high from the cycle after an accepted start until DONE.
- `done`  out  1: one-cycle pulse at pass end.

## Operation
- `inst` fields:
  - [18] div, [17] acc, [16] ofifo_rd.
  - [15:12] q/k mem addr, [11:8] pmem addr.
  - [7] array execute, [6] array kernel-load.
  - [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr.
- qmem_wr and kmem_wr are never asserted (memories are preloaded externally).
- Every bit not listed for a state is 0.
- States and `inst` content:
  - IDLE: inst = 0.
    - start=1 → KLOAD; latch n and norm_en; clear the counter.
  - KLOAD: kmem_rd=1, [6]=1, addr = cnt.
    - After `col` cycles (cnt 0..col-1) → KFLUSH.
  - KFLUSH: inst = 0 for `kflush` cycles → EXEC.
  - EXEC: qmem_rd=1, [7]=1, addr = cnt, 0..n-1 → DRAIN.
  - DRAIN: each cycle with fifo_valid=1, assert ofifo_rd=1 and pmem_wr=1 with pmem addr = cnt, then cnt++.
    - fifo_valid=0 means stall: inst = 0, cnt held.
    - After n pops: norm_en → NACC, else DONE.
  - NACC: pmem_rd=1, acc=1, pmem addr 0..n-1 → NGAP.
  - NGAP: one cycle with inst = 0 → NDIV.
  - NDIV: pmem_rd=1, div=1, pmem addr 0..n-1 → NDRAIN.
  - NDRAIN: same rule as DRAIN, but pmem addr = norm_base + cnt; after n pops → DONE.
  - DONE: inst = 0, done=1 for one cycle → IDLE.
- Counter: 4 bits, cleared on every state entry. Address fields take the low 4 bits of the counter or sum; norm_base + 7 must be ≤ 15.
- `start` while busy: ignored, no queueing.

## Timing
- Reset values: inst=0, busy=0, done=0, state=IDLE, counter=0. All take effect immediately on reset assertion.
- Reset asserted mid-pass aborts the pass: inst is 0 from the reset edge, and no done pulse is produced.
- `inst` is a flop output: the word for state S is visible in the cycle the FSM occupies S.
- The first KLOAD word appears on the cycle after start is sampled.
- Latencies with no stalls, measured from the start-sample edge:
  - last EXEC word at cycle col + kflush + n;
  - done = col + kflush + 2n + 1 (norm off);
  - done = col + kflush + 5n + 2 (norm on).
- DRAIN/NDRAIN: ofifo_rd and pmem_wr are always in the same cycle and depend combinationally on registered state plus the fifo_valid sampled that cycle. The `inst` register is loaded from next-state logic, so fifo_valid is consumed one cycle before the word appears.
- No pop is issued without fifo_valid. Pops never exceed n per drain phase.

## Structure
- Shared package `core_inst_pkg` holds:
  - `inst` bit-position localparams;
  - the state enum (IDLE, KLOAD, KFLUSH, EXEC, DRAIN, NACC, NGAP, NDIV, NDRAIN, DONE);
  - the `inst` width (19).
- One natural sub-module, `inst_encode`: pure combinational mapping (state, counter, base) → next `inst` word. The FSM, counter and output register live in `core_seq`.

## Test plan
- Reset mid-pass: assert reset during EXEC.
  - inst=0 immediately, busy=0, no done.
  - A start after release runs a clean pass.
- num_q=3, norm_en=0, fifo_valid always 1.
  - Kmem addrs 0..7 with bit 6 set.
  - 2 zero words.
  - Qmem addrs 0..3 with bit 7 set.
  - pmem_wr addrs 0..3 with ofifo_rd.
  - done at cycle 19.
- Same pass, fifo_valid low for 3 cycles after the 2nd pop.
  - Exactly 4 pops total; pmem addrs 0,1,2,3 contiguous.
  - done delayed by 3 cycles.
- num_q=7, norm_en=1.
  - NACC reads 0..7 with acc=1, then one zero word.
  - NDIV reads 0..7 with div=1.
  - NDRAIN writes 8..15.
  - done at cycle 52.
- start pulsed during KLOAD and during DRAIN → ignored; exactly one done.

Source files
------------

// File: rtl/core_inst_pkg.sv
// Shared definitions for the core instruction sequencer: inst word layout and FSM states.
package core_inst_pkg;

    localparam int unsigned InstW = 19;

    // inst bit positions
    localparam int unsigned BitDiv     = 18;
    localparam int unsigned BitAcc     = 17;
    localparam int unsigned BitOfifoRd = 16;
    localparam int unsigned QkAddrLsb  = 12;
    localparam int unsigned PAddrLsb   = 8;
    localparam int unsigned BitExec    = 7;
    localparam int unsigned BitKload   = 6;
    localparam int unsigned BitQmemRd  = 5;
    localparam int unsigned BitQmemWr  = 4;
    localparam int unsigned BitKmemRd  = 3;
    localparam int unsigned BitKmemWr  = 2;
    localparam int unsigned BitPmemRd  = 1;
    localparam int unsigned BitPmemWr  = 0;

    typedef enum logic [3:0] {
        StIdle,
        StKload,
        StKflush,
        StExec,
        StDrain,
        StNacc,
        StNgap,
        StNdiv,
        StNdrain,
        StDone
    } state_e;

    // States whose words pop the output FIFO only when fifo_valid allows it
    function automatic logic is_drain(state_e s);
        return (s == StDrain) || (s == StNdrain);
    endfunction

endpackage

// File: rtl/inst_encode.sv
// Pure combinational map from (state, counter, pop) to the inst word for that state.
module inst_encode
    import core_inst_pkg::*;
#(
    parameter int unsigned norm_base = 8
) (
    input  state_e                 state_i,
    input  logic [3:0]             cnt_i,
    input  logic                   pop_i,
    output logic [InstW-1:0]       inst_o
);

    localparam logic [3:0] NormBase = 4'(norm_base);

    // Build the word; all unlisted bits stay 0 (qmem_wr/kmem_wr never set)
    always_comb begin
        inst_o = '0;
        unique case (state_i)
            StKload: begin
                inst_o[BitKmemRd]          = 1'b1;
                inst_o[BitKload]           = 1'b1;
                inst_o[QkAddrLsb +: 4]     = cnt_i;
            end
            StExec: begin
                inst_o[BitQmemRd]          = 1'b1;
                inst_o[BitExec]            = 1'b1;
                inst_o[QkAddrLsb +: 4]     = cnt_i;
            end
            StDrain: begin
                if (pop_i) begin
                    inst_o[BitOfifoRd]     = 1'b1;
                    inst_o[BitPmemWr]      = 1'b1;
                    inst_o[PAddrLsb +: 4]  = cnt_i;
                end
            end
            StNacc: begin
                inst_o[BitPmemRd]          = 1'b1;
                inst_o[BitAcc]             = 1'b1;
                inst_o[PAddrLsb +: 4]      = cnt_i;
            end
            StNdiv: begin
                inst_o[BitPmemRd]          = 1'b1;
                inst_o[BitDiv]             = 1'b1;
                inst_o[PAddrLsb +: 4]      = cnt_i;
            end
            StNdrain: begin
                if (pop_i) begin
                    inst_o[BitOfifoRd]     = 1'b1;
                    inst_o[BitPmemWr]      = 1'b1;
                    inst_o[PAddrLsb +: 4]  = NormBase + cnt_i;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/core_seq.sv
// Instruction sequencer: walks kernel load, execute, drain and optional normalization,
// emitting one registered inst word per cycle.
module core_seq
    import core_inst_pkg::*;
#(
    parameter int unsigned col       = 8,
    parameter int unsigned kflush    = 2,
    parameter int unsigned norm_base = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       num_q,
    input  logic             norm_en,
    input  logic             fifo_valid,
    output logic [InstW-1:0] inst,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] ColLast    = 4'(col - 1);
    localparam logic [3:0] KflushLast = 4'(kflush - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       last_q, last_d;   // n-1
    logic             norm_q, norm_d;
    logic [InstW-1:0] inst_q, inst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pop;
    logic [3:0]       addr_cnt;
    logic [3:0]       n_rows;

    assign n_rows = last_q + 4'd1;

    // State, counter, latched pass config and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= '0;
            norm_q  <= 1'b0;
            inst_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            norm_q  <= norm_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state: in drain states cnt_q counts pops already issued into inst
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        norm_d  = norm_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StKload;
                    last_d  = {1'b0, num_q};
                    norm_d  = norm_en;
                end
            end
            StKload:  if (cnt_q == ColLast)    state_d = StKflush;
            StKflush: if (cnt_q == KflushLast) state_d = StExec;
            StExec:   if (cnt_q == last_q)     state_d = StDrain;
            StDrain:  if (cnt_q == n_rows)     state_d = norm_q ? StNacc : StDone;
            StNacc:   if (cnt_q == last_q)     state_d = StNgap;
            StNgap:                            state_d = StNdiv;
            StNdiv:   if (cnt_q == last_q)     state_d = StNdrain;
            StNdrain: if (cnt_q == n_rows)     state_d = StDone;
            StDone:                            state_d = StIdle;
            default:                           state_d = StIdle;
        endcase
    end

    // Outputs: next word is encoded from next state, so fifo_valid is consumed a cycle early
    always_comb begin
        pop      = 1'b0;
        addr_cnt = '0;
        cnt_d    = '0;
        if (is_drain(state_d)) begin
            pop      = fifo_valid;
            addr_cnt = (state_d != state_q) ? 4'd0 : cnt_q;
            cnt_d    = addr_cnt + {3'b000, pop};
        end else if ((state_d != state_q) || (state_d == StIdle)) begin
            cnt_d    = '0;
            addr_cnt = '0;
        end else begin
            cnt_d    = cnt_q + 4'd1;
            addr_cnt = cnt_d;
        end
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    inst_encode #(
        .norm_base (norm_base)
    ) u_inst_encode (
        .state_i (state_d),
        .cnt_i   (addr_cnt),
        .pop_i   (pop),
        .inst_o  (inst_d)
    );

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_core_seq.sv
// Directed, table-driven bench for core_seq.
module tb_core_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  num_q;
    logic        norm_en;
    logic        fifo_valid;
    logic [18:0] inst;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    core_seq #(
        .col       (8),
        .kflush    (2),
        .norm_base (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_q      (num_q),
        .norm_en    (norm_en),
        .fifo_valid (fifo_valid),
        .inst       (inst),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        int          cyc;
        logic [18:0] inst;
        logic        done;
    } vec_t;

    vec_t        vecs[$];
    logic [18:0] tr_inst[64];
    logic        tr_done[64];
    logic        tr_busy[64];
    int          checks   = 0;
    int          failures = 0;

    // Hand-assembled inst words
    function automatic logic [18:0] w_kl(int a);
        return 19'(32'h48 | (a << 12));
    endfunction
    function automatic logic [18:0] w_ex(int a);
        return 19'(32'hA0 | (a << 12));
    endfunction
    function automatic logic [18:0] w_pop(int p);
        return 19'(32'h10001 | (p << 8));
    endfunction
    function automatic logic [18:0] w_acc(int p);
        return 19'(32'h20002 | (p << 8));
    endfunction
    function automatic logic [18:0] w_div(int p);
        return 19'(32'h40002 | (p << 8));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected per-cycle table; stall cycles follow the 2nd pop of the first drain
    task automatic build(input int n, input logic nrm, input int stall, input int last);
        logic [18:0] ei[64];
        logic        ed[64];
        int          d0;
        int          a;
        for (int c = 0; c < 64; c++) begin
            ei[c] = '0;
            ed[c] = 1'b0;
        end
        for (int i = 0; i < 8; i++) ei[1 + i] = w_kl(i);
        for (int i = 0; i < n; i++) ei[11 + i] = w_ex(i);
        d0 = 11 + n;
        for (int i = 0; i < n; i++) ei[d0 + i + ((i >= 2) ? stall : 0)] = w_pop(i);
        a = d0 + n + stall;
        if (nrm) begin
            for (int i = 0; i < n; i++) begin
                ei[a + i]             = w_acc(i);
                ei[a + n + 1 + i]     = w_div(i);
                ei[a + 2*n + 1 + i]   = w_pop(8 + i);
            end
            ed[a + 3*n + 1] = 1'b1;
        end else begin
            ed[a] = 1'b1;
        end
        vecs.delete();
        for (int c = 0; c <= last; c++) vecs.push_back('{cyc: c, inst: ei[c], done: ed[c]});
    endtask

    // Cycle 0 is the cycle start is high; record each cycle at the falling edge
    task automatic run_pass(input int n, input logic nrm, input int stall,
                            input int inj_a, input int inj_b, input int last);
        int d0;
        d0 = 11 + n;
        @(negedge clk);
        num_q   = 3'(n - 1);
        norm_en = nrm;
        for (int k = 0; k <= last; k++) begin
            tr_inst[k] = inst;
            tr_done[k] = done;
            tr_busy[k] = busy;
            start      = (k == 0) || (k == inj_a) || (k == inj_b);
            fifo_valid = !((k > d0) && (k <= d0 + stall));
            @(negedge clk);
        end
        start      = 1'b0;
        fifo_valid = 1'b1;
    endtask

    task automatic compare(input string tag, input int last);
        int ndone;
        ndone = 0;
        foreach (vecs[i]) begin
            check($sformatf("%s inst@%0d", tag, vecs[i].cyc), 32'(tr_inst[vecs[i].cyc]),
                  32'(vecs[i].inst));
            check($sformatf("%s done@%0d", tag, vecs[i].cyc), 32'(tr_done[vecs[i].cyc]),
                  32'(vecs[i].done));
        end
        for (int c = 0; c <= last; c++) if (tr_done[c]) ndone++;
        check($sformatf("%s done_count", tag), 32'(ndone), 32'd1);
        check($sformatf("%s busy@0", tag), 32'(tr_busy[0]), 32'd0);
        check($sformatf("%s busy@5", tag), 32'(tr_busy[5]), 32'd1);
        check($sformatf("%s busy@end", tag), 32'(tr_busy[last]), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        num_q      = '0;
        norm_en    = 1'b0;
        fifo_valid = 1'b1;
        #1;
        check("reset inst", 32'(inst), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of EXEC aborts the pass
        num_q   = 3'd3;
        norm_en = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("pre-reset exec word", 32'(inst), 32'(w_ex(1)));
        #2 reset = 1'b1;
        #1;
        check("midreset inst", 32'(inst), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("postreset done@%0d", k), 32'(done), 32'd0);
            check($sformatf("postreset inst@%0d", k), 32'(inst), 32'd0);
        end

        // Clean pass after reset: n=4, no norm, no stalls
        build(4, 1'b0, 0, 21);
        run_pass(4, 1'b0, 0, -1, -1, 21);
        compare("A", 21);

        // fifo_valid low for 3 cycles after the 2nd pop
        build(4, 1'b0, 3, 24);
        run_pass(4, 1'b0, 3, -1, -1, 24);
        compare("B", 24);

        // n=8 with normalization
        build(8, 1'b1, 0, 54);
        run_pass(8, 1'b1, 0, -1, -1, 54);
        compare("C", 54);

        // start pulses during KLOAD and DRAIN are ignored
        build(4, 1'b0, 0, 24);
        run_pass(4, 1'b0, 0, 3, 16, 24);
        compare("D", 24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule
